// File: rtl/rshift_seq.sv
// ---------------------------------------------------------------------------
// rshift_seq -- multi-cycle right shifter (SRL / SRA, optional rotate-right)
//
// Resolves one shift-amount bit per clock, MSB first. A request is accepted
// in IDLE (or in DONE while the result is being consumed). It then spends
// SHAMT_W clocks in SHIFT and presents the result in DONE until the consumer
// takes it. Latency is fixed and does not depend on the shift distance.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds its data and valid
// until that edge. Ready may depend combinationally on the peer's ready
// (in_ready follows out_ready while in DONE), but never on in_valid.
//
// Optional feature: define RSHIFT_ROTATE_EN to add the `rotate` input.
// rotate=1 selects rotate-right and takes priority over arith.
//
// Ports
//   clock      in   1        rising-edge clock
//   reset      in   1        asynchronous, active-high reset
//   in_valid   in   1        request present on operand/shift_amt/arith
//   in_ready   out  1        request can be accepted this cycle
//   operand    in   WIDTH    value to shift
//   shift_amt  in   SHAMT_W  shift distance, 0..WIDTH-1
//   arith      in   1        1 = sign fill, 0 = zero fill
//   rotate     in   1        (RSHIFT_ROTATE_EN only) 1 = rotate-right
//   out_valid  out  1        result holds a completed shift
//   out_ready  in   1        consumer takes result this cycle
//   result     out  WIDTH    shifted value, held until next completion/reset
//   busy       out  1        high while in SHIFT
//   dbg_state  out  2        current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
// ---------------------------------------------------------------------------
module rshift_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shift_amt,
    input  logic               arith,
`ifdef RSHIFT_ROTATE_EN
    input  logic               rotate,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    // Stage counter only needs to reach SHAMT_W-1.
    localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [K_W-1:0]   K_LAST  = K_W'(SHAMT_W - 1);
    localparam logic [SHAMT_W:0] WIDTH_L = (SHAMT_W + 1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [SHAMT_W-1:0] amt_q;
    logic               mode_q;
    logic [K_W-1:0]     k_q;
    logic [WIDTH-1:0]   result_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               accept;
`ifdef RSHIFT_ROTATE_EN
    logic               rot_q;
    logic [SHAMT_W:0]   back;
`endif

    logic [SHAMT_W-1:0] step;
    logic [WIDTH-1:0]   shr;
    logic [WIDTH-1:0]   sra;
    logic [WIDTH-1:0]   shifted;

    // in_ready is the only combinational output: in DONE a new request can
    // be taken on the same edge that the current result is consumed.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = 1'b1;
            SHIFT:   in_ready = 1'b0;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready;

    // One stage of the barrel: distance 2^k, applied only if amt[k] is set.
    // For SRA the fill comes from acc's MSB, which still holds the original
    // sign because every earlier stage also sign-filled.
    always_comb begin
        step    = SHAMT_W'(1) << k_q;
        shr     = acc_q >> step;
        sra     = $signed(acc_q) >>> step;
        shifted = mode_q ? sra : shr;
`ifdef RSHIFT_ROTATE_EN
        // step >= 1, so back stays below WIDTH and the left shift is legal.
        back = WIDTH_L - {1'b0, step};
        if (rot_q) begin
            shifted = shr | (acc_q << back);
        end
`endif
        acc_d = amt_q[k_q] ? shifted : acc_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            amt_q       <= '0;
            mode_q      <= 1'b0;
            k_q         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RSHIFT_ROTATE_EN
            rot_q       <= 1'b0;
`endif
        end else if (accept) begin
            // Covers IDLE and DONE-with-consume: inputs are sampled only here.
            acc_q       <= operand;
            amt_q       <= shift_amt;
            mode_q      <= arith;
`ifdef RSHIFT_ROTATE_EN
            rot_q       <= rotate;
`endif
            k_q         <= K_LAST;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SHIFT;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    if (k_q == '0) begin
                        result_q    <= acc_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
